// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment display front end: converter states,
// digit count and the active-low segment patterns.
package ssd_pkg;

    localparam int DIGITS = 4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t CONV  = 2'd1;
    localparam state_t LATCH = 2'd2;

    // {g,f,e,d,c,b,a}, common anode, so a lit segment is a 0
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_LUT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        if (code <= 4'd9) begin
            pattern = SEG_LUT[code];
        end
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one binary bit per clock, result copied to
// the digit outputs only when the whole conversion has finished.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int NUM_W = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_W-1:0] num,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [3:0]       thou,
    output logic [3:0]       hund,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    localparam int                ITER_W    = $clog2(NUM_W + 1);
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_W - 1);

    state_t              state;
    logic [NUM_W-1:0]    shreg;
    logic [4*DIGITS-1:0] work;
    logic [4*DIGITS-1:0] work_adj;
    logic [ITER_W-1:0]   iter;

    always_comb begin
        // NOTE: the default copy keeps every bit assigned on every pass, so no latch is inferred.
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            work  <= '0;
            iter  <= '0;
            done  <= 1'b0;
            thou  <= '0;
            hund  <= '0;
            tens  <= '0;
            ones  <= '0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values, as the hardware does.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg <= num;
                        work  <= '0;
                        iter  <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    // MSB of the captured value enters the ones nibble first
                    {work, shreg} <= {work_adj, shreg} << 1;
                    iter          <= iter + 1'b1;
                    if (iter == LAST_ITER) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    {thou, hund, tens, ones} <= work;
                    done                     <= 1'b1;
                    state                    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment front end: BCD conversion plus a free-running digit scanner.
// Define LEADING_ZERO_BLANK_EN to leave leading-zero digit slots dark.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_W       = 13,
    parameter int REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_W-1:0]  num,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]        digit [DIGITS];
    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        scan_idx;
    logic [DIGITS-1:0] lead_zero;

    bin2bcd_seq #(
        .NUM_W (NUM_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .thou  (digit[3]),
        .hund  (digit[2]),
        .tens  (digit[1]),
        .ones  (digit[0])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
        end else if (refresh_cnt == LAST_CNT) begin
            refresh_cnt <= '0;
            scan_idx    <= scan_idx + 1'b1;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    // A slot is a leading zero when it and every higher digit are zero; ones is always shown.
    always_comb begin
        lead_zero = '0;
`ifdef LEADING_ZERO_BLANK_EN
        lead_zero[DIGITS-1] = (digit[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 1; i--) begin
            lead_zero[i] = lead_zero[i+1] && (digit[i] == 4'd0);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode <= '1;
            seg   <= SEG_BLANK;
        end else if (lead_zero[scan_idx]) begin
            anode <= '1;
            seg   <= SEG_BLANK;
        end else begin
            anode <= ~(DIGITS'(1) << scan_idx);
            seg   <= seg_encode(digit[scan_idx]);
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomised bench for ssd_scan_ctrl against a cycle-level behavioural model
// built from decimal arithmetic; honours LEADING_ZERO_BLANK_EN when defined.
module tb_ssd_scan_ctrl;

    localparam int DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] num;
    logic        load;
    logic        busy;
    logic        done;
    logic [3:0]  anode;
    logic [6:0]  seg;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int         m_busy_left;
    int         m_pending;
    int         m_disp;
    int         m_ref;
    int         m_idx;
    bit         m_done;
    logic [3:0] m_anode;
    logic [6:0] m_seg;

    ssd_scan_ctrl #(
        .NUM_W       (13),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .anode (anode),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0:       return 7'h40;
            1:       return 7'h79;
            2:       return 7'h24;
            3:       return 7'h30;
            4:       return 7'h19;
            5:       return 7'h12;
            6:       return 7'h02;
            7:       return 7'h78;
            8:       return 7'h00;
            9:       return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] anode_of(input int idx);
        case (idx)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic int pow10(input int e);
        int p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    task automatic model_reset();
        m_busy_left = 0;
        m_pending   = 0;
        m_disp      = 0;
        m_ref       = 0;
        m_idx       = 0;
        m_done      = 1'b0;
        m_anode     = 4'b1111;
        m_seg       = 7'h7F;
    endtask

    // One clock edge of the specified behaviour, using pre-edge model values.
    task automatic model_edge();
        if (LZB && m_idx != 0 && m_disp < pow10(m_idx)) begin
            m_anode = 4'b1111;
            m_seg   = 7'h7F;
        end else begin
            m_anode = anode_of(m_idx);
            m_seg   = seg_of((m_disp / pow10(m_idx)) % 10);
        end
        if (m_ref == DIV - 1) begin
            m_ref = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_ref++;
        end
        m_done = 1'b0;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_disp = m_pending;
                m_done = 1'b1;
            end
        end else if (load) begin
            m_pending   = int'(num);
            m_busy_left = 14;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check("busy",  32'(busy),  32'(m_busy_left > 0));
        check("done",  32'(done),  32'(m_done));
        check("anode", 32'(anode), 32'(m_anode));
        check("seg",   32'(seg),   32'(m_seg));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_load(input int value);
        num  = 13'(value);
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_anode", 32'(anode), 32'(4'b1111));
        check("rst_seg",   32'(seg),   32'(7'h7F));
        check("rst_busy",  32'(busy),  32'(1'b0));
        check("rst_done",  32'(done),  32'(1'b0));
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        load  = 1'b0;
        num   = '0;
        model_reset();
        @(negedge clk);
        async_reset();
        idle(20);

        // Nominal conversion, then boundary values
        do_load(1234);
        idle(30);
        do_load(8191);
        idle(30);
        do_load(0);
        idle(30);

        // Load while busy and num changes mid-conversion are both ignored
        do_load(3456);
        idle(3);
        num  = 13'd42;
        load = 1'b1;
        tick();
        load = 1'b0;
        idle(4);
        num = 13'd999;
        idle(25);

        // Back-to-back: second load lands in the done cycle
        do_load(5678);
        idle(14);
        do_load(2024);
        idle(14);

        // Full scan of 5678
        do_load(5678);
        idle(34);

        // Abort at iteration 6, then a single-digit value
        do_load(4321);
        idle(6);
        async_reset();
        idle(20);
        do_load(7);
        idle(30);

        // Random traffic with occasional resets
        repeat (400) begin
            num  = 13'($urandom_range(0, 8191));
            load = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
            end else begin
                tick();
            end
        end
        load = 1'b0;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
